booth4_digit_accumulator: RTL

- Consumer end of the radix-16 Booth digit interface. Takes the stream of (neg, weight) digit pairs that a Booth encoder stage produces and turns it back into a full product.
- Each digit is decoded to its signed value. The matching multiple of a latched multiplicand is formed, shifted by the digit position and accumulated, one digit per cycle.
- Sits in the RV64IM multiplier datapath between the digit encoder and the writeback mux.

---
 rtl/booth4_digit_accumulator_pkg.sv | 28 ++
 rtl/booth4_digit_accumulator_decode.sv | 25 ++
 rtl/booth4_digit_accumulator.sv | 100 ++++++++++
 3 files changed

// File: rtl/booth4_digit_accumulator_pkg.sv
// Shared definitions for the radix-16 Booth multiplier datapath:
// operand/product widths, accumulator FSM states and the digit record
// passed from the digit encoder to the digit accumulator.
package booth4_digit_accumulator_pkg;

    localparam int XLEN = 64;
    localparam int NDIG = 16;
    localparam int PW   = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic       neg;
        logic [3:0] weight;
    } booth_digit_t;

    // Signed digit value: neg ? -(weight+1) : weight, range -16..15.
    function automatic logic signed [5:0] digit_value(input logic neg, input logic [3:0] weight);
        logic signed [5:0] w;
        w = signed'({2'b00, weight});
        return neg ? -(w + 6'sd1) : w;
    endfunction

endpackage

// File: rtl/booth4_digit_accumulator_decode.sv
// Booth digit decoder: turns one (neg, weight) digit into the exact signed
// multiple d*M of the multiplicand. Purely combinational.
module booth4_digit_decode #(
    parameter int XLEN = booth4_digit_accumulator_pkg::XLEN
) (
    input  logic                   neg,
    input  logic [3:0]             weight,
    input  logic signed [XLEN-1:0] mcand,
    output logic signed [XLEN+4:0] multiple
);
    import booth4_digit_accumulator_pkg::*;

    logic signed [5:0]      d;
    logic signed [XLEN+4:0] m_ext;
    logic signed [XLEN+4:0] d_ext;

    // |d*M| <= 16*2^(XLEN-1), so XLEN+5 signed bits hold the product exactly.
    always_comb begin
        d        = digit_value(neg, weight);
        m_ext    = {{5{mcand[XLEN-1]}}, mcand};
        d_ext    = {{(XLEN-1){d[5]}}, d};
        multiple = m_ext * d_ext;
    end

endmodule

// File: rtl/booth4_digit_accumulator.sv
// Radix-16 Booth digit accumulator: latches a multiplicand, then consumes
// NDIG signed digits (least significant first), adding d_i*M*16^i into a
// PW-bit accumulator, and presents the product with a valid/ready handshake.
module booth4_digit_accumulator #(
    parameter int XLEN = booth4_digit_accumulator_pkg::XLEN,
    parameter int NDIG = booth4_digit_accumulator_pkg::NDIG,
    parameter int PW   = booth4_digit_accumulator_pkg::PW
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_start_valid,
    output logic                   io_start_ready,
    input  logic signed [XLEN-1:0] io_mcand,
    input  logic                   io_dig_valid,
    output logic                   io_dig_ready,
    input  logic                   io_neg,
    input  logic [3:0]             io_weight,
    output logic                   io_out_valid,
    input  logic                   io_out_ready,
    output logic [PW-1:0]          io_prod,
    input  logic                   io_flush
);
    import booth4_digit_accumulator_pkg::*;

    localparam int             IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NDIG - 1);

    state_e                 state;
    logic signed [XLEN-1:0] mcand_q;
    logic [PW-1:0]          acc;
    logic [IW-1:0]          idx;
    booth_digit_t           dig;
    logic signed [XLEN+4:0] multiple;
    logic [PW-1:0]          pp_ext;
    logic [PW-1:0]          pp_shift;

    assign dig = '{neg: io_neg, weight: io_weight};

    booth4_digit_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .neg      (dig.neg),
        .weight   (dig.weight),
        .mcand    (mcand_q),
        .multiple (multiple)
    );

    // Sign-extend the digit multiple to product width and align it to the
    // current digit position (4 bits per radix-16 digit).
    always_comb begin
        pp_ext   = {{(PW-XLEN-5){multiple[XLEN+4]}}, multiple};
        pp_shift = pp_ext << {idx, 2'b00};
    end

    assign io_start_ready = (state == ST_IDLE);
    assign io_dig_ready   = (state == ST_ACCUM);
    assign io_out_valid   = (state == ST_DONE);
    assign io_prod        = acc;

    // Operation FSM with accumulator and digit index; flush overrides all.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            acc     <= '0;
            idx     <= '0;
            mcand_q <= '0;
        end else if (io_flush) begin
            state <= ST_IDLE;
            acc   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io_start_valid) begin
                        mcand_q <= io_mcand;
                        acc     <= '0;
                        idx     <= '0;
                        state   <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (io_dig_valid) begin
                        acc <= acc + pp_shift;
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (io_out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
